// File: rtl/segre_pkg.sv
// rtl/segre_pkg.sv - shared types and sizes for the segre store drain path
package segre_pkg;

  localparam int WORD_SIZE      = 32;
  localparam int WCB_LINE_BYTES = 16;
  localparam int M              = $clog2(WCB_LINE_BYTES);
  // Address bits below N select the byte and the set; bits above form the tag.
  localparam int N              = 10;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } memop_data_type_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    MERGING = 2'd1,
    WRITING = 2'd2
  } wcb_state_e;

endpackage

// File: rtl/segre_wcb_merge.sv
// rtl/segre_wcb_merge.sv - merges one store entry into a byte-enabled line image
module segre_wcb_merge
  import segre_pkg::*;
#(
  parameter int LINE_BYTES = WCB_LINE_BYTES
) (
  input  logic [8*LINE_BYTES-1:0]       line_i,
  input  logic [LINE_BYTES-1:0]         be_i,
  input  logic [$clog2(LINE_BYTES)-1:0] off_i,
  input  logic [WORD_SIZE-1:0]          data_i,
  input  memop_data_type_e              type_i,
  output logic [8*LINE_BYTES-1:0]       line_o,
  output logic [LINE_BYTES-1:0]         be_o
);

  localparam int LM = $clog2(LINE_BYTES);

  logic [LM-1:0] base;
  logic [LM-1:0] lane;
  logic [2:0]    nbytes;

  always_comb begin
    base   = off_i;
    nbytes = 3'd0;
    case (type_i)
      BYTE: begin
        base   = off_i;
        nbytes = 3'd1;
      end
      HALF: begin
        base   = off_i & ~LM'(1);
        nbytes = 3'd2;
      end
      WORD: begin
        base   = off_i & ~LM'(3);
        nbytes = 3'd4;
      end
      default: begin
        base   = off_i;
        nbytes = 3'd0;
      end
    endcase

    line_o = line_i;
    be_o   = be_i;
    lane   = base;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < nbytes) begin
        lane                 = base + LM'(k);
        line_o[8*lane +: 8]  = data_i[8*k +: 8];
        be_o[lane]           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/segre_write_combine_buffer.sv
// rtl/segre_write_combine_buffer.sv - single-line write-combining buffer after the store buffer
// Optional idle write-out timer: define SEGRE_WCB_TIMEOUT_EN.
module segre_write_combine_buffer
  import segre_pkg::*;
#(
  parameter int LINE_BYTES     = WCB_LINE_BYTES,
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                                clk_i,
  input  logic                                rsn_i,
  input  logic                                sb_valid_i,
  input  logic [WORD_SIZE-1:0]                sb_data_i,
  input  logic [WORD_SIZE-1:0]                sb_addr_i,
  input  memop_data_type_e                    sb_data_type_i,
  output logic                                sb_ready_o,
  input  logic                                flush_i,
  output logic                                wr_req_o,
  input  logic                                wr_ack_i,
  output logic [WORD_SIZE-N-1:0]              wr_tag_o,
  output logic [N-$clog2(LINE_BYTES)-1:0]     wr_index_o,
  output logic [8*LINE_BYTES-1:0]             wr_data_o,
  output logic [LINE_BYTES-1:0]               wr_be_o,
  input  logic [WORD_SIZE-1:0]                probe_addr_i,
  output logic                                probe_hit_o,
  output logic                                empty_o
);

  localparam int LM = $clog2(LINE_BYTES);
  localparam int LW = WORD_SIZE - LM;

  wcb_state_e              state_q;
  logic [LW-1:0]           line_q;
  logic [8*LINE_BYTES-1:0] data_q;
  logic [LINE_BYTES-1:0]   be_q;

  logic [8*LINE_BYTES-1:0] data_d;
  logic [LINE_BYTES-1:0]   be_d;
  logic [LINE_BYTES-1:0]   be_base;
  logic                    same_line;
  logic                    accept;
  logic                    timeout;

  assign same_line = (sb_addr_i[WORD_SIZE-1:LM] == line_q);
  assign accept    = sb_valid_i && sb_ready_o;
  // A fresh line starts from empty enables; stale image bytes are masked off.
  assign be_base   = (state_q == EMPTY) ? '0 : be_q;

  segre_wcb_merge #(
    .LINE_BYTES (LINE_BYTES)
  ) u_merge (
    .line_i (data_q),
    .be_i   (be_base),
    .off_i  (sb_addr_i[LM-1:0]),
    .data_i (sb_data_i),
    .type_i (sb_data_type_i),
    .line_o (data_d),
    .be_o   (be_d)
  );

  always_comb begin
    sb_ready_o = 1'b0;
    case (state_q)
      EMPTY:   sb_ready_o = !flush_i;
      MERGING: sb_ready_o = sb_valid_i ? (same_line && !flush_i) : !flush_i;
      WRITING: sb_ready_o = 1'b0;
      default: sb_ready_o = 1'b0;
    endcase
  end

`ifdef SEGRE_WCB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  assign timeout = (state_q == MERGING) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      cnt_q <= '0;
    end else if (accept || state_q != MERGING) begin
      cnt_q <= '0;
    end else if (!timeout) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic unused_timeout_cycles;
  assign timeout               = 1'b0;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= EMPTY;
      line_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            line_q  <= sb_addr_i[WORD_SIZE-1:LM];
            data_q  <= data_d;
            be_q    <= be_d;
            state_q <= MERGING;
          end
        end
        MERGING: begin
          if (accept) begin
            data_q <= data_d;
            be_q   <= be_d;
          end else if ((sb_valid_i && !same_line) || flush_i || timeout) begin
            // An all-zero mask (only from an unknown data type) has nothing to write.
            state_q <= (be_q != '0) ? WRITING : EMPTY;
          end
        end
        WRITING: begin
          if (wr_ack_i) begin
            be_q    <= '0;
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign wr_req_o   = (state_q == WRITING);
  assign wr_tag_o   = line_q[LW-1 -: (WORD_SIZE - N)];
  assign wr_index_o = line_q[N-LM-1:0];
  assign wr_data_o  = data_q;
  assign wr_be_o    = be_q;
  assign empty_o    = (state_q == EMPTY);
  assign probe_hit_o = (state_q != EMPTY) && (probe_addr_i[WORD_SIZE-1:LM] == line_q);

  logic unused_probe_offset;
  assign unused_probe_offset = ^probe_addr_i[LM-1:0];

endmodule

// File: tb/tb_segre_write_combine_buffer.sv
// tb/tb_segre_write_combine_buffer.sv - directed self-checking bench for segre_write_combine_buffer
module tb_segre_write_combine_buffer;
  import segre_pkg::*;

  logic                    clk = 1'b0;
  logic                    rsn;
  logic                    sb_valid;
  logic [WORD_SIZE-1:0]    sb_data;
  logic [WORD_SIZE-1:0]    sb_addr;
  memop_data_type_e        sb_type;
  logic                    sb_ready;
  logic                    flush;
  logic                    wr_req;
  logic                    wr_ack;
  logic [WORD_SIZE-N-1:0]  wr_tag;
  logic [N-M-1:0]          wr_index;
  logic [8*WCB_LINE_BYTES-1:0] wr_data;
  logic [WCB_LINE_BYTES-1:0]   wr_be;
  logic [WORD_SIZE-1:0]    probe;
  logic                    probe_hit;
  logic                    empty;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  segre_write_combine_buffer #(
    .LINE_BYTES     (16),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i          (clk),
    .rsn_i          (rsn),
    .sb_valid_i     (sb_valid),
    .sb_data_i      (sb_data),
    .sb_addr_i      (sb_addr),
    .sb_data_type_i (sb_type),
    .sb_ready_o     (sb_ready),
    .flush_i        (flush),
    .wr_req_o       (wr_req),
    .wr_ack_i       (wr_ack),
    .wr_tag_o       (wr_tag),
    .wr_index_o     (wr_index),
    .wr_data_o      (wr_data),
    .wr_be_o        (wr_be),
    .probe_addr_i   (probe),
    .probe_hit_o    (probe_hit),
    .empty_o        (empty)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input memop_data_type_e t, input logic [31:0] a, input logic [31:0] d);
    sb_valid = 1'b1;
    sb_type  = t;
    sb_addr  = a;
    sb_data  = d;
  endtask

  task automatic ack_write();
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
  endtask

  task automatic test_reset();
    rsn = 1'b0; sb_valid = 1'b0; sb_data = '0; sb_addr = '0; sb_type = BYTE;
    flush = 1'b0; wr_ack = 1'b0; probe = '0;
    step(); step();
    checks++; if (wr_req !== 1'b0) $display("FAIL reset_req got %0h exp 0", wr_req); else passed++;
    checks++; if (wr_be !== 16'h0) $display("FAIL reset_be got %0h exp 0", wr_be); else passed++;
    checks++; if (wr_data !== '0) $display("FAIL reset_data got %0h exp 0", wr_data); else passed++;
    checks++; if (wr_tag !== '0 || wr_index !== '0) $display("FAIL reset_tag_index got %0h/%0h exp 0/0", wr_tag, wr_index); else passed++;
    checks++; if (probe_hit !== 1'b0) $display("FAIL reset_probe got %0h exp 0", probe_hit); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %0h exp 1", empty); else passed++;
    checks++; if (sb_ready !== 1'b1) $display("FAIL reset_ready got %0h exp 1", sb_ready); else passed++;
    flush = 1'b1; #1;
    checks++; if (sb_ready !== 1'b0) $display("FAIL reset_ready_flush got %0h exp 0", sb_ready); else passed++;
    flush = 1'b0;
    @(negedge clk);
    rsn = 1'b1;
    step();
    checks++; if (empty !== 1'b1) $display("FAIL empty_flush_noeffect got %0h exp 1", empty); else passed++;
  endtask

  task automatic test_combine();
    set_store(WORD, 32'h100, 32'h11223344); #1;
    checks++; if (sb_ready !== 1'b1) $display("FAIL comb_ready0 got %0h exp 1", sb_ready); else passed++;
    step();
    checks++; if (empty !== 1'b0) $display("FAIL comb_empty got %0h exp 0", empty); else passed++;
    set_store(BYTE, 32'h105, 32'h000000AA); #1;
    checks++; if (sb_ready !== 1'b1) $display("FAIL comb_ready1 got %0h exp 1", sb_ready); else passed++;
    step();
    set_store(WORD, 32'h200, 32'hCAFEF00D); #1;
    checks++; if (sb_ready !== 1'b0) $display("FAIL comb_ready_other got %0h exp 0", sb_ready); else passed++;
    step();
    checks++; if (wr_req !== 1'b1) $display("FAIL comb_req got %0h exp 1", wr_req); else passed++;
    checks++; if (wr_index !== 6'h10 || wr_tag !== '0) $display("FAIL comb_line got %0h/%0h exp 0/10", wr_tag, wr_index); else passed++;
    checks++; if (wr_be !== 16'h002F) $display("FAIL comb_be got %0h exp 002f", wr_be); else passed++;
    checks++; if (wr_data[31:0] !== 32'h11223344) $display("FAIL comb_word got %0h exp 11223344", wr_data[31:0]); else passed++;
    checks++; if (wr_data[47:40] !== 8'hAA) $display("FAIL comb_byte5 got %0h exp aa", wr_data[47:40]); else passed++;
    checks++; if (sb_ready !== 1'b0) $display("FAIL comb_ready_writing got %0h exp 0", sb_ready); else passed++;
    ack_write();
    checks++; if (empty !== 1'b1 || wr_req !== 1'b0) $display("FAIL comb_after_ack got %0h/%0h exp 1/0", empty, wr_req); else passed++;
    #1;
    checks++; if (sb_ready !== 1'b1) $display("FAIL comb_ready_empty got %0h exp 1", sb_ready); else passed++;
    step();
    sb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (wr_req !== 1'b1 || wr_index !== 6'h20) $display("FAIL comb2_line got %0h/%0h exp 1/20", wr_req, wr_index); else passed++;
    checks++; if (wr_be !== 16'h000F || wr_data[31:0] !== 32'hCAFEF00D) $display("FAIL comb2_payload got %0h/%0h exp f/cafef00d", wr_be, wr_data[31:0]); else passed++;
    ack_write();
  endtask

  task automatic test_flush_half();
    set_store(WORD, 32'h40, 32'hDEADBEEF);
    step();
    set_store(HALF, 32'h42, 32'h00001234);
    step();
    sb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (wr_req !== 1'b1) $display("FAIL half_req got %0h exp 1", wr_req); else passed++;
    checks++; if (wr_data[31:0] !== 32'h1234BEEF) $display("FAIL half_word got %0h exp 1234beef", wr_data[31:0]); else passed++;
    checks++; if (wr_be !== 16'h000F || wr_index !== 6'h04) $display("FAIL half_be_idx got %0h/%0h exp f/4", wr_be, wr_index); else passed++;
    ack_write();
  endtask

  task automatic test_timeout();
    set_store(BYTE, 32'h31, 32'h0000005A);
    step();
    sb_valid = 1'b0;
`ifdef SEGRE_WCB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (wr_req !== (i == 8)) $display("FAIL timeout_edge%0d got %0h exp %0h", i, wr_req, (i == 8));
      else passed++;
    end
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (wr_req !== 1'b0) $display("FAIL notimeout_edge%0d got %0h exp 0", i, wr_req);
      else passed++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (wr_req !== 1'b1) $display("FAIL notimeout_flush got %0h exp 1", wr_req); else passed++;
`endif
    checks++; if (wr_be !== 16'h0002 || wr_data[15:8] !== 8'h5A) $display("FAIL timeout_payload got %0h/%0h exp 2/5a", wr_be, wr_data[15:8]); else passed++;
    ack_write();
  endtask

  task automatic test_ack_stall();
    set_store(WORD, 32'h80, 32'hA5A50F0F);
    step();
    sb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; probe = 32'h84; #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wr_req !== 1'b1 || wr_be !== 16'h000F || wr_data[31:0] !== 32'hA5A50F0F)
        $display("FAIL stall_cycle%0d got %0h/%0h/%0h exp 1/f/a5a50f0f", i, wr_req, wr_be, wr_data[31:0]);
      else passed++;
      checks++; if (probe_hit !== 1'b1) $display("FAIL stall_probe%0d got %0h exp 1", i, probe_hit); else passed++;
      step();
    end
    probe = 32'h90; #1;
    checks++; if (probe_hit !== 1'b0) $display("FAIL stall_probe_other got %0h exp 0", probe_hit); else passed++;
    probe = '0;
    ack_write();
    checks++; if (empty !== 1'b1) $display("FAIL stall_empty got %0h exp 1", empty); else passed++;
    ack_write();
    checks++; if (empty !== 1'b1 || wr_req !== 1'b0) $display("FAIL stray_ack got %0h/%0h exp 1/0", empty, wr_req); else passed++;
  endtask

  task automatic test_flush_same_line();
    set_store(WORD, 32'hC0, 32'h01020304);
    step();
    set_store(BYTE, 32'hC8, 32'h000000EE);
    flush = 1'b1; #1;
    checks++; if (sb_ready !== 1'b0) $display("FAIL fsl_ready got %0h exp 0", sb_ready); else passed++;
    step();
    flush = 1'b0;
    checks++; if (wr_req !== 1'b1 || wr_be !== 16'h000F) $display("FAIL fsl_write got %0h/%0h exp 1/f", wr_req, wr_be); else passed++;
    #1;
    checks++; if (sb_ready !== 1'b0) $display("FAIL fsl_ready_writing got %0h exp 0", sb_ready); else passed++;
    ack_write();
    #1;
    checks++; if (sb_ready !== 1'b1 || empty !== 1'b1) $display("FAIL fsl_ready_empty got %0h/%0h exp 1/1", sb_ready, empty); else passed++;
    step();
    sb_valid = 1'b0;
    checks++; if (empty !== 1'b0) $display("FAIL fsl_accepted got %0h exp 0", empty); else passed++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (wr_be !== 16'h0100 || wr_data[71:64] !== 8'hEE || wr_index !== 6'h0C)
      $display("FAIL fsl_second got %0h/%0h/%0h exp 100/ee/c", wr_be, wr_data[71:64], wr_index); else passed++;
    ack_write();
  endtask

  task automatic test_reset_mid_write();
    set_store(WORD, 32'h300, 32'h00000055);
    step();
    sb_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; probe = 32'h300;
    checks++; if (wr_req !== 1'b1) $display("FAIL rmw_pre got %0h exp 1", wr_req); else passed++;
    #2 rsn = 1'b0;
    #1;
    checks++; if (wr_req !== 1'b0 || wr_be !== 16'h0) $display("FAIL rmw_req_be got %0h/%0h exp 0/0", wr_req, wr_be); else passed++;
    checks++; if (wr_data !== '0 || wr_tag !== '0 || wr_index !== '0) $display("FAIL rmw_payload got %0h/%0h/%0h exp 0", wr_data, wr_tag, wr_index); else passed++;
    checks++; if (empty !== 1'b1 || probe_hit !== 1'b0 || sb_ready !== 1'b1)
      $display("FAIL rmw_status got %0h/%0h/%0h exp 1/0/1", empty, probe_hit, sb_ready); else passed++;
    @(negedge clk);
    rsn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (wr_req !== 1'b0 || empty !== 1'b1) $display("FAIL rmw_after%0d got %0h/%0h exp 0/1", i, wr_req, empty); else passed++;
    end
    probe = '0;
  endtask

  initial begin
    test_reset();
    test_combine();
    test_flush_half();
    test_timeout();
    test_ack_stall();
    test_flush_same_line();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
